// File: rtl/blockram_clr_if.sv
// Port bundle for blockram_clr: read port, byte-enabled write port and clear control.
// The master drives requests; the slave (the RAM) returns read data, valid and busy.
interface blockram_clr_if #(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 11
) ();
  logic                     ReadEnable;
  logic [AddrWidth-1:0]     ReadAddr;
  logic [DataWidth-1:0]     ReadData;
  logic                     ReadValid;
  logic                     WriteEnable;
  logic [AddrWidth-1:0]     WriteAddr;
  logic [DataWidth-1:0]     WriteData;
  logic [DataWidth/8-1:0]   WriteByteEnable;
  logic                     ClearStart;
  logic                     Busy;

  modport master (
    output ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteData, WriteByteEnable, ClearStart,
    input  ReadData, ReadValid, Busy
  );

  modport slave (
    input  ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteData, WriteByteEnable, ClearStart,
    output ReadData, ReadValid, Busy
  );
endinterface

// File: rtl/blockram_clr.sv
// Simple-dual-port byte-enabled block RAM with write-first bypass and a zero-fill
// sequencer that sweeps every word after reset and on ClearStart.
module blockram_clr #(
  parameter int                   DataWidth  = 16,
  parameter int                   Depth      = 2048,
  parameter int                   AddrWidth  = $clog2(Depth),
  parameter logic [DataWidth-1:0] ClearValue = '0
) (
  input  logic          Clk,
  input  logic          nReset,
  blockram_clr_if.slave bus
);
  localparam int                   ByteLanes = DataWidth / 8;
  localparam logic [AddrWidth:0]   DepthExt  = (AddrWidth + 1)'(Depth);
  localparam logic [AddrWidth-1:0] LastAddr  = AddrWidth'(Depth - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t               r_state;
  logic [AddrWidth-1:0] r_clr_addr;
  logic [DataWidth-1:0] r_read_data;
  logic                 r_read_valid;

  logic                 w_idle;
  logic                 w_clr_we;
  logic                 w_wr_ok;
  logic                 w_rd_in_range;
  logic                 w_same_addr;
  logic [DataWidth-1:0] w_rd_word;

  assign w_idle        = (r_state == ST_IDLE);
  assign w_clr_we      = (r_state == ST_CLEAR);
  assign w_wr_ok       = w_idle && bus.WriteEnable && ({1'b0, bus.WriteAddr} < DepthExt);
  assign w_rd_in_range = ({1'b0, bus.ReadAddr} < DepthExt);
  assign w_same_addr   = (bus.WriteAddr == bus.ReadAddr);

  // One narrow array per byte lane so each lane has its own write enable.
  genvar gi;
  generate
    for (gi = 0; gi < ByteLanes; gi++) begin : g_lane
      logic [7:0] r_lane_mem [Depth];

      always_ff @(posedge Clk) begin
        if (w_clr_we) begin
          r_lane_mem[r_clr_addr] <= ClearValue[8*gi +: 8];
        end else if (w_wr_ok && bus.WriteByteEnable[gi]) begin
          r_lane_mem[bus.WriteAddr] <= bus.WriteData[8*gi +: 8];
        end
      end

      // Write-first per lane: an enabled lane being written this edge returns the new byte.
      assign w_rd_word[8*gi +: 8] = (w_wr_ok && bus.WriteByteEnable[gi] && w_same_addr)
                                    ? bus.WriteData[8*gi +: 8]
                                    : r_lane_mem[bus.ReadAddr];
    end
  endgenerate

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state      <= ST_CLEAR;
      r_clr_addr   <= '0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
    end else begin
      r_read_valid <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_addr == LastAddr) begin
            r_state    <= ST_IDLE;
            r_clr_addr <= '0;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
          end
        end
        default: begin
          if (bus.ReadEnable) begin
            r_read_valid <= 1'b1;
            r_read_data  <= w_rd_in_range ? w_rd_word : ClearValue;
          end
          if (bus.ClearStart) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
          end
        end
      endcase
    end
  end

  assign bus.ReadData  = r_read_data;
  assign bus.ReadValid = r_read_valid;
  assign bus.Busy      = (r_state == ST_CLEAR);
endmodule

// File: tb/tb_blockram_clr.sv
// Bench for blockram_clr: two instances (Depth 2048 and 1000) driven by directed and
// random traffic, checked every cycle against a word-level memory model.
module tb_blockram_clr;
  logic clk;
  logic nreset;

  logic        re  [2];
  logic [10:0] ra  [2];
  logic        we  [2];
  logic [10:0] wa  [2];
  logic [15:0] wd  [2];
  logic [1:0]  wbe [2];
  logic        cs  [2];

  logic [15:0] rd_o   [2];
  logic        rv_o   [2];
  logic        busy_o [2];

  int n_checks;
  int n_errors;

  blockram_clr_if #(.DataWidth(16), .AddrWidth(11)) bus0 ();
  blockram_clr_if #(.DataWidth(16), .AddrWidth(10)) bus1 ();

  blockram_clr #(.DataWidth(16), .Depth(2048)) dut0 (.Clk(clk), .nReset(nreset), .bus(bus0));
  blockram_clr #(.DataWidth(16), .Depth(1000)) dut1 (.Clk(clk), .nReset(nreset), .bus(bus1));

  assign bus0.ReadEnable      = re[0];
  assign bus0.ReadAddr        = ra[0];
  assign bus0.WriteEnable     = we[0];
  assign bus0.WriteAddr       = wa[0];
  assign bus0.WriteData       = wd[0];
  assign bus0.WriteByteEnable = wbe[0];
  assign bus0.ClearStart      = cs[0];
  assign bus1.ReadEnable      = re[1];
  assign bus1.ReadAddr        = ra[1][9:0];
  assign bus1.WriteEnable     = we[1];
  assign bus1.WriteAddr       = wa[1][9:0];
  assign bus1.WriteData       = wd[1];
  assign bus1.WriteByteEnable = wbe[1];
  assign bus1.ClearStart      = cs[1];

  assign rd_o[0]   = bus0.ReadData;
  assign rd_o[1]   = bus1.ReadData;
  assign rv_o[0]   = bus0.ReadValid;
  assign rv_o[1]   = bus1.ReadValid;
  assign busy_o[0] = bus0.Busy;
  assign busy_o[1] = bus1.Busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dep(input int u);
    return (u == 0) ? 2048 : 1000;
  endfunction

  task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s unit%0d actual=%h required=%h t=%0t", name, u, act, exp, $time);
    end
  endtask

  // Model: contents as a plain word array, a countdown of remaining sweep cycles,
  // and the read result the next edge must present.
  logic [15:0] m_mem  [2][2048];
  int          m_left [2];
  logic [15:0] m_rd   [2];
  logic        m_rv   [2];

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_left[u] = dep(u);
      m_rd[u]   = 16'h0000;
      m_rv[u]   = 1'b0;
    end
  endtask

  always @(negedge nreset) model_reset();

  always @(posedge clk) begin
    if (!nreset) begin
      model_reset();
    end else begin
      for (int u = 0; u < 2; u++) begin
        int          a_r;
        int          a_w;
        logic [15:0] w;
        a_r = (u == 1) ? int'(ra[u][9:0]) : int'(ra[u]);
        a_w = (u == 1) ? int'(wa[u][9:0]) : int'(wa[u]);
        if (m_left[u] > 0) begin
          m_rv[u]   = 1'b0;
          m_left[u] = m_left[u] - 1;
          if (m_left[u] == 0) begin
            for (int a = 0; a < dep(u); a++) m_mem[u][a] = 16'h0000;
          end
        end else begin
          m_rv[u] = re[u];
          if (re[u]) begin
            if (a_r >= dep(u)) begin
              m_rd[u] = 16'h0000;
            end else begin
              w = m_mem[u][a_r];
              if (we[u] && a_w == a_r) begin
                for (int l = 0; l < 2; l++) if (wbe[u][l]) w[8*l +: 8] = wd[u][8*l +: 8];
              end
              m_rd[u] = w;
            end
          end
          if (we[u] && a_w < dep(u)) begin
            w = m_mem[u][a_w];
            for (int l = 0; l < 2; l++) if (wbe[u][l]) w[8*l +: 8] = wd[u][8*l +: 8];
            m_mem[u][a_w] = w;
          end
          if (cs[u]) m_left[u] = dep(u);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      check("busy",   u, 32'(busy_o[u]), 32'(m_left[u] > 0));
      check("rvalid", u, 32'(rv_o[u]),   32'(m_rv[u]));
      check("rdata",  u, 32'(rd_o[u]),   32'(m_rd[u]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    for (int u = 0; u < 2; u++) begin
      re[u] = 1'b0; ra[u] = '0; we[u] = 1'b0; wa[u] = '0;
      wd[u] = '0;   wbe[u] = '0; cs[u] = 1'b0;
    end
  endtask

  task automatic wr(input int u, input logic [10:0] a, input logic [15:0] d, input logic [1:0] be);
    we[u] = 1'b1; wa[u] = a; wd[u] = d; wbe[u] = be;
    tick();
    we[u] = 1'b0;
  endtask

  // Read with literal expectation; also pins the model and the one-cycle valid pulse.
  task automatic rd(input int u, input logic [10:0] a, input logic [15:0] exp, input string name);
    re[u] = 1'b1; ra[u] = a;
    tick();
    re[u] = 1'b0;
    check({name, "_valid"}, u, 32'(rv_o[u]), 32'd1);
    check({name, "_data"},  u, 32'(rd_o[u]), 32'(exp));
    check({name, "_model"}, u, 32'(m_rd[u]), 32'(exp));
    tick();
    check({name, "_pulse"}, u, 32'(rv_o[u]), 32'd0);
  endtask

  // Counts edges until both units drop Busy; a unit that never drops reports 0.
  task automatic measure_busy(output int b0, output int b1);
    b0 = 0; b1 = 0;
    for (int n = 1; n <= 2200; n++) begin
      tick();
      if (!busy_o[0] && b0 == 0) b0 = n;
      if (!busy_o[1] && b1 == 0) b1 = n;
      if (b0 != 0 && b1 != 0) break;
    end
  endtask

  int b0;
  int b1;

  initial begin
    n_checks = 0;
    n_errors = 0;
    nreset   = 1'b0;
    idle_inputs();
    tick(); tick(); tick();
    check("reset_busy",  0, 32'(busy_o[0]), 32'd1);
    check("reset_valid", 0, 32'(rv_o[0]),   32'd0);
    check("reset_data",  0, 32'(rd_o[0]),   32'd0);

    nreset = 1'b1;
    measure_busy(b0, b1);
    check("sweep_len", 0, 32'(b0), 32'd2048);
    check("sweep_len", 1, 32'(b1), 32'd1000);

    rd(0, 11'd0,    16'h0000, "rd0");
    rd(0, 11'd1023, 16'h0000, "rd1023");
    rd(0, 11'd2047, 16'h0000, "rd2047");

    wr(0, 11'd5, 16'hBEEF, 2'b11);
    wr(0, 11'd5, 16'h1234, 2'b01);
    rd(0, 11'd5, 16'hBE34, "lane_merge");

    wr(0, 11'd9, 16'h1111, 2'b11);
    we[0] = 1'b1; wa[0] = 11'd9; wd[0] = 16'hA55A; wbe[0] = 2'b10;
    re[0] = 1'b1; ra[0] = 11'd9;
    tick();
    we[0] = 1'b0; re[0] = 1'b0;
    check("bypass_valid", 0, 32'(rv_o[0]), 32'd1);
    check("bypass_data",  0, 32'(rd_o[0]), 32'h0000A511);
    rd(0, 11'd9, 16'hA511, "after_bypass");

    wr(0, 11'd100, 16'hFFFF, 2'b11);
    rd(0, 11'd100, 16'hFFFF, "pre_clear");
    cs[0] = 1'b1;
    tick();
    cs[0] = 1'b0;
    b0 = 0;
    for (int n = 1; n <= 2200; n++) begin
      re[0] = 1'b1; ra[0] = 11'd100;
      we[0] = 1'b1; wa[0] = 11'd100; wd[0] = 16'($urandom); wbe[0] = 2'b11;
      tick();
      if (rv_o[0]) check("clear_rvalid", 0, 32'(rv_o[0]), 32'd0);
      if (!busy_o[0]) begin
        b0 = n;
        break;
      end
    end
    idle_inputs();
    check("clear_len", 0, 32'(b0), 32'd2048);
    rd(0, 11'd100, 16'h0000, "post_clear");

    wr(1, 11'd0,    16'h7777, 2'b11);
    wr(1, 11'd999,  16'h8888, 2'b11);
    wr(1, 11'd1000, 16'hDEAD, 2'b11);
    rd(1, 11'd0,    16'h7777, "oor_keep0");
    rd(1, 11'd999,  16'h8888, "oor_keep999");
    rd(1, 11'd1000, 16'h0000, "oor_read");
    rd(1, 11'd1023, 16'h0000, "oor_top");

    // Reset partway into a sweep: both units must restart from word 0.
    cs[0] = 1'b1; cs[1] = 1'b1;
    tick();
    idle_inputs();
    for (int n = 0; n < 500; n++) tick();
    nreset = 1'b0;
    tick(); tick();
    check("midreset_busy", 0, 32'(busy_o[0]), 32'd1);
    check("midreset_data", 0, 32'(rd_o[0]),   32'd0);
    nreset = 1'b1;
    measure_busy(b0, b1);
    check("resweep_len", 0, 32'(b0), 32'd2048);
    check("resweep_len", 1, 32'(b1), 32'd1000);
    rd(1, 11'd0, 16'h0000, "resweep_zero");

    for (int c = 0; c < 4000; c++) begin
      for (int u = 0; u < 2; u++) begin
        int base;
        int top;
        base = (u == 0) ? 0 : 992;
        top  = (u == 0) ? 2047 : 1023;
        re[u]  = 1'($urandom_range(0, 1));
        we[u]  = 1'($urandom_range(0, 1));
        ra[u]  = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, top)) : 11'(base + int'($urandom_range(0, 15)));
        wa[u]  = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, top)) : 11'(base + int'($urandom_range(0, 15)));
        wd[u]  = 16'($urandom);
        wbe[u] = 2'($urandom_range(0, 3));
        cs[u]  = ($urandom_range(0, 1499) == 0);
      end
      tick();
    end
    idle_inputs();
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
